// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 key schedule and round datapath.
// Contents: schedule FSM state type, schedule geometry constants, the round
// constant table and the byte substitution (S-box) lookup function.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NR          = 10;
  localparam int ROUND_KEY_W = 128;
  localparam int OUT_W       = (NR + 1) * ROUND_KEY_W;

  // Indexed directly by the 4-bit round counter; entries outside 1..10 are
  // padding so any counter value stays inside the table.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES byte substitution.
// Ports: din (8-bit byte in), dout (8-bit substituted byte out).
// Used four times for SubWord in the key schedule; also suited to SubBytes.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = sbox(din);

endmodule

// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule: one round key per clock, 11 round keys total.
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-low reset
//   start  - level request, sampled only while idle
//   key    - 128-bit cipher key (key[127:96] is word w0)
//   finish - registered, high while the full schedule is held on out
//   out    - 1408-bit flat bus, out[1407:1280] = rk0 ... out[127:0] = rk10
module aes_key_expansion
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [127:0]       key,
  output logic               finish,
  output logic [OUT_W-1:0]   out
);

  state_t                 state_r;
  state_t                 state_next_s;
  logic [3:0]             cnt_r;
  logic [127:0]           work_r;
  logic [OUT_W-1:0]       out_r;
  logic                   finish_r;

  logic [31:0]            w0_s, w1_s, w2_s, w3_s;
  logic [31:0]            rot_s;
  logic [31:0]            sub_s;
  logic [31:0]            t_s;
  logic [31:0]            nw0_s, nw1_s, nw2_s, nw3_s;
  logic [127:0]           next_rk_s;

  assign w0_s = work_r[127:96];
  assign w1_s = work_r[95:64];
  assign w2_s = work_r[63:32];
  assign w3_s = work_r[31:0];

  // RotWord: rotate the last word left by one byte
  assign rot_s = {w3_s[23:0], w3_s[31:24]};

  aes_sbox u_sbox3 (.din(rot_s[31:24]), .dout(sub_s[31:24]));
  aes_sbox u_sbox2 (.din(rot_s[23:16]), .dout(sub_s[23:16]));
  aes_sbox u_sbox1 (.din(rot_s[15:8]),  .dout(sub_s[15:8]));
  aes_sbox u_sbox0 (.din(rot_s[7:0]),   .dout(sub_s[7:0]));

  // The round counter doubles as the Rcon index since it runs 1..10 in BUSY
  assign t_s = sub_s ^ {RCON[cnt_r], 24'h000000};

  // The four words chain serially; this XOR ladder is the critical path
  assign nw0_s     = w0_s ^ t_s;
  assign nw1_s     = w1_s ^ nw0_s;
  assign nw2_s     = w2_s ^ nw1_s;
  assign nw3_s     = w3_s ^ nw2_s;
  assign next_rk_s = {nw0_s, nw1_s, nw2_s, nw3_s};

  // Next-state logic for the schedule controller
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r >= 4'(NR)) begin
          state_next_s = DONE;
        end else begin
          state_next_s = BUSY;
        end
      end
      DONE: begin
        // Holding here while start stays high prevents a retrigger
        if (start) begin
          state_next_s = DONE;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, counter, working words, round-key slots and finish flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      work_r   <= 128'd0;
      out_r    <= '0;
      finish_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      // Derived from the next state so finish is a plain flop output
      finish_r <= (state_next_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            work_r                                 <= key;
            out_r[OUT_W-1 -: ROUND_KEY_W]          <= key;
            cnt_r                                  <= 4'd1;
          end
        end
        BUSY: begin
          work_r <= next_rk_s;
          cnt_r  <= cnt_r + 4'd1;
          for (int s = 1; s <= NR; s++) begin
            if (cnt_r == 4'(s)) begin
              out_r[(NR - s) * ROUND_KEY_W +: ROUND_KEY_W] <= next_rk_s;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign finish = finish_r;
  assign out    = out_r;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion. The reference model builds the
// S-box from GF(2^8) inversion plus the affine map and expands keys word by
// word over a 44-entry array, independent of the RTL tables.
module tb_aes_key_expansion;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [127:0]   key;
  logic           finish;
  logic [1407:0]  out;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb_tab [256];

  aes_key_expansion dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .key    (key),
    .finish (finish),
    .out    (out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] b;
    for (int i = 0; i < 256; i++) begin
      b   = 8'(i);
      inv = 8'h01;
      if (i == 0) inv = 8'h00;
      else for (int j = 0; j < 254; j++) inv = gf_mul(inv, b);
      sb_tab[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [1407:0] expand(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]};
        t  = t ^ {rc, 24'h000000};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) r[1407 - 32*i -: 32] = w[i];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns to idle, pulses start with k, then counts edges after the
  // accepting edge until finish rises (bounded).
  task automatic run_key(input logic [127:0] k, output int lat, output logic fin_e0);
    start = 1'b0;
    tick();
    tick();
    key   = k;
    start = 1'b1;
    tick();
    fin_e0 = finish;
    start  = 1'b0;
    key    = rand128();
    lat    = 0;
    while (finish !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b1;
    key   = rand128();
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (finish !== 1'b0 || out !== 1408'd0) begin
        bad++;
        $display("FAIL reset_hold cycle=%0d finish=%b exp=0 out_nonzero=%b", i, finish, |out);
      end
    end
    start = 1'b0;
    rst   = 1'b1;
    tick();
    total++;
    if (finish !== 1'b0 || out !== 1408'd0) begin
      bad++;
      $display("FAIL reset_release finish=%b exp=0 out_nonzero=%b", finish, |out);
    end
  endtask

  task automatic test_fips();
    logic [127:0] k;
    int           lat;
    logic         fin_e0;
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    run_key(k, lat, fin_e0);
    total++;
    if (fin_e0 !== 1'b0) begin
      bad++;
      $display("FAIL fips_finish_e0 got=%b exp=0", fin_e0);
    end
    total++;
    if (lat !== 10) begin
      bad++;
      $display("FAIL fips_latency got=%0d exp=10", lat);
    end
    total++;
    if (out[1407:1280] !== k) begin
      bad++;
      $display("FAIL fips_rk0 got=%h exp=%h", out[1407:1280], k);
    end
    total++;
    if (out[1279:1152] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      bad++;
      $display("FAIL fips_rk1 got=%h exp=a0fafe1788542cb123a339392a6c7605", out[1279:1152]);
    end
    total++;
    if (out[127:0] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      bad++;
      $display("FAIL fips_rk10 got=%h exp=d014f9a8c9ee2589e13f0cc8b6630ca6", out[127:0]);
    end
    total++;
    if (out !== expand(k)) begin
      bad++;
      $display("FAIL fips_all got=%h exp=%h", out, expand(k));
    end
  endtask

  task automatic test_zero_key();
    int   lat;
    logic fin_e0;
    run_key(128'd0, lat, fin_e0);
    total++;
    if (out[1279:1152] !== 128'h62636363626363636263636362636363) begin
      bad++;
      $display("FAIL zero_rk1 got=%h exp=62636363626363636263636362636363", out[1279:1152]);
    end
    total++;
    if (out[127:0] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
      bad++;
      $display("FAIL zero_rk10 got=%h exp=b4ef5bcb3e92e21123e951cf6f8f188e", out[127:0]);
    end
    total++;
    if (finish !== 1'b1 || lat !== 10) begin
      bad++;
      $display("FAIL zero_finish finish=%b lat=%0d exp finish=1 lat=10", finish, lat);
    end
  endtask

  task automatic test_random();
    logic [127:0] k;
    int           lat;
    logic         fin_e0;
    for (int n = 0; n < 5; n++) begin
      k = rand128();
      run_key(k, lat, fin_e0);
      total++;
      if (out !== expand(k) || lat !== 10) begin
        bad++;
        $display("FAIL random_%0d key=%h lat=%0d exp_lat=10 got=%h exp=%h", n, k, lat, out, expand(k));
      end
    end
  endtask

  task automatic test_held_start();
    logic [127:0]  k1, k2;
    logic [1407:0] e1;
    int            lat;
    k1 = rand128();
    k2 = rand128();
    e1 = expand(k1);
    start = 1'b0;
    tick();
    tick();
    key   = k1;
    start = 1'b1;
    lat   = 0;
    while (finish !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    total++;
    if (out !== e1 || lat !== 11) begin
      bad++;
      $display("FAIL held_first lat=%0d exp_lat=11 got=%h exp=%h", lat, out, e1);
    end
    key = k2;
    for (int i = 0; i < 55; i++) begin
      tick();
      total++;
      if (finish !== 1'b1 || out !== e1) begin
        bad++;
        $display("FAIL held_stable cycle=%0d finish=%b exp=1 out_match=%b", i, finish, out === e1);
      end
    end
    start = 1'b0;
    tick();
    total++;
    if (finish !== 1'b0 || out !== e1) begin
      bad++;
      $display("FAIL held_drop finish=%b exp=0 out_held=%b exp=1", finish, out === e1);
    end
    key   = k2;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    while (finish !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    total++;
    if (out !== expand(k2) || lat !== 10) begin
      bad++;
      $display("FAIL held_restart lat=%0d exp_lat=10 got=%h exp=%h", lat, out, expand(k2));
    end
  endtask

  task automatic test_busy_ignore();
    logic [127:0] k;
    int           lat;
    k = rand128();
    start = 1'b0;
    tick();
    tick();
    key   = k;
    start = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      key   = rand128();
      start = ~start;
      tick();
    end
    start = 1'b0;
    lat   = 6;
    while (finish !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    total++;
    if (out !== expand(k) || lat !== 10) begin
      bad++;
      $display("FAIL busy_ignore lat=%0d exp_lat=10 got=%h exp=%h", lat, out, expand(k));
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] k;
    int           lat;
    logic         fin_e0;
    k = rand128();
    start = 1'b0;
    tick();
    tick();
    key   = k;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (out !== 1408'd0 || finish !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_async finish=%b exp=0 out_nonzero=%b exp=0", finish, |out);
    end
    tick();
    rst = 1'b1;
    k = rand128();
    run_key(k, lat, fin_e0);
    total++;
    if (out !== expand(k) || lat !== 10) begin
      bad++;
      $display("FAIL reset_mid_rerun lat=%0d exp_lat=10 got=%h exp=%h", lat, out, expand(k));
    end
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    key   = 128'd0;
    build_sbox();
    test_reset();
    test_fips();
    test_zero_key();
    test_random();
    test_held_start();
    test_busy_ignore();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_key_expansion.md
# aes_key_expansion

Iterative AES-128 key schedule. Accepts a 128-bit cipher key on a start request and produces all 11 round keys (44 words, 1408 bits) over 10 clock cycles, one round key per cycle. It sits ahead of the AES round datapath, which consumes the flat round-key bus once `finish` is high.

## Interface
- No parameters. Key size is fixed at AES-128: Nk=4, Nr=10.
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `start`  in  1  level request; sampled only in IDLE.
- `key`  in  128  cipher key; `key[127:96]` is word w0, `key[31:0]` is w3; byte 0 is `key[127:120]`.
- `finish`  out  1  high while a complete schedule is held on `out`.
- `out`  out  1408  round keys packed MSB-first: `out[1407:1280]` = round key 0 (= key), then rk1, …, `out[127:0]` = rk10; within each round key the word order matches `key`.

## Operation
- FSM states:
  - IDLE -> BUSY on `start`=1.
  - BUSY -> BUSY while round counter < 10.
  - BUSY -> DONE after rk10 is written.
  - DONE -> IDLE when `start`=0.
  - DONE holds while `start`=1, so a held-high start does not retrigger.
- IDLE accepting `start`: load `key` into the rk0 slot and into working registers w[0..3]; round counter := 1.
- Each BUSY cycle, with round index i = 1..10:
  - t = SubWord(RotWord(w3)) XOR {Rcon[i], 24'h0}.
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - Write {w0',w1',w2',w3'} to slot i; update working registers; counter++.
- RotWord: {b1,b2,b3,b0}. SubWord: the standard AES S-box applied to each of the 4 bytes (4 combinational lookups).
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- `start` and `key` are ignored in BUSY and DONE. `key` may change after the accepting edge without effect.
- `out` slots fill progressively during BUSY. `out` is valid only when `finish`=1 and is held unchanged in DONE and in the following IDLE until the next accepted start.
- On a new start, slots are overwritten in order. Stale slots from the previous run remain until overwritten.

## Timing
- Reset (async, `rst`=0): state IDLE, counter 0, `out`=0, `finish`=0. Reset asserted mid-BUSY aborts immediately to this state.
- Edge E0, with start=1 in IDLE: rk0 registered, `finish`=0.
- Edges E1..E10: rk1..rk10 registered.
- `finish` goes high after E10, i.e. 10 cycles after E0. It stays high through DONE and deasserts on the edge that leaves DONE. It is registered (no combinational path from `start`).
- Minimum restart: start low for 1 cycle in DONE (returns to IDLE), then start high.
- One S-box pass per cycle. The critical path is S-box plus 4 chained 32-bit XORs.

## Structure
- Package `aes_pkg`:
  - state enum (IDLE/BUSY/DONE)
  - Rcon constant table
  - constants NR=10, ROUND_KEY_W=128
  - S-box function
- Sub-module `aes_sbox`: 8-bit combinational S-box, instantiated 4× for SubWord and reusable by the SubBytes stage of the cipher.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse:
  - rk1 = a0fafe1788542cb123a339392a6c7605
  - rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - `out[1407:1280]` = key
  - `finish` rises exactly 10 cycles after the accepting edge.
- All-zero key:
  - rk1 = 62636363626363636263636362636363
  - rk10 = b4ef5bcb3e92e21123e951cf6f8f188e
- Start held high continuously: single run, `finish` stays high, `out` is stable for 50+ cycles. Drop start -> `finish` falls; raise it with a new key -> new schedule.
- Change `key` and pulse `start` during BUSY: ignored, and the result equals the original key's schedule.
- Assert `rst`=0 at the 5th BUSY cycle:
  - `out`=0 and `finish`=0 immediately (asynchronously).
  - After release, a fresh start yields the correct schedule.
- Reset held low with start=1: `finish` stays 0 and `out` stays 0.
